// File: rtl/uriscv_muldiv.sv
// Iterative RV-M multiply/divide unit: shift-add multiply and restoring divide,
// one result bit per clock, fixed WIDTH-cycle latency with a valid/ready handshake.
module uriscv_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  input  logic             ready_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               divz_q, divz_d;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                        input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0]        a_mag, b_mag;

  assign a_s = a_i;
  assign b_s = b_i;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_i)
      3'd0, 3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'd2:                   a_sgn = 1'b1;
      default:                ;
    endcase
  end

  assign a_neg = a_sgn && (a_s < 0);
  assign b_neg = b_sgn && (b_s < 0);
  assign a_mag = cond_neg(a_i, a_neg);
  assign b_mag = cond_neg(b_i, b_neg);

  // One iteration of each algorithm; acc holds {hi, lo} = {partial/remainder, multiplier/quotient}
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, iter_next, prod;
  logic [WIDTH-1:0]   quo, rem, mul_res, div_res, fin_res;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb_q};
  assign div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign iter_next = op_q[2] ? div_next : mul_next;

  // Sign fix-up on the final iteration; divide-by-zero quotient is forced to all ones
  assign prod    = cond_neg_wide(iter_next, neg_q);
  assign mul_res = (op_q[1:0] == 2'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  assign quo     = divz_q ? '1 : cond_neg(iter_next[WIDTH-1:0], neg_q);
  assign rem     = cond_neg(iter_next[2*WIDTH-1:WIDTH], rneg_q);
  assign div_res = op_q[1] ? rem : quo;
  assign fin_res = op_q[2] ? div_res : mul_res;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    divz_d   = divz_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = op_i;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          divz_d  = (b_i == '0);
          if (op_i[2]) begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            opb_d = b_mag;
          end else begin
            acc_d = {{WIDTH{1'b0}}, b_mag};
            opb_d = a_mag;
          end
        end
      end
      S_RUN: begin
        acc_d = iter_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) begin
          result_d = fin_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      divz_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      divz_q   <= divz_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_uriscv_muldiv.sv
// Scoreboard bench for uriscv_muldiv: directed RV-M vectors, latency, hold,
// flush and mid-operation reset behaviour.
module tb_uriscv_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;

  always #5 clk = ~clk;

  uriscv_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op), .a_i(a), .b_i(b), .flush_i(flush_i),
    .valid_o(valid_o), .result_o(result), .ready_i(ready_i)
  );

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on rising valid_o, value on every valid cycle, pop on handshake
  always @(negedge clk) begin
    if (valid_o) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", {{(W-1){1'b0}}, valid_o}, '0);
      end else begin
        if (!prev_v) check({sbq[0].name, "_latency"}, W'(cyc), W'(sbq[0].cyc));
        check(sbq[0].name, result, sbq[0].res);
        if (ready_i) void'(sbq.pop_front());
      end
    end
    prev_v = valid_o;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] e, input string nm, input bit push);
    int n = 0;
    while (!ready_o && n < 200) begin step(1); n++; end
    if (!ready_o) begin
      check({nm, "_ready_timeout"}, {{(W-1){1'b0}}, ready_o}, 1);
      return;
    end
    valid_i = 1'b1; op = o; a = x; b = y;
    if (push) sbq.push_back('{e, cyc + 1 + W, nm});
    step(1);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin step(1); n++; end
    if (sbq.size() != 0) begin
      check("drain_timeout", W'(sbq.size()), '0);
      sbq.delete();
    end
  endtask

  initial begin
    int hi_cnt;
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    op = '0; a = '0; b = '0;
    step(3);
    rst = 1'b0;
    check("reset_ready", {{(W-1){1'b0}}, ready_o}, 1);
    check("reset_valid", {{(W-1){1'b0}}, valid_o}, 0);
    check("reset_result", result, 0);

    // Basic MUL with ready_o low throughout RUN
    issue(3'd0, 32'd7, 32'd6, 32'h0000002A, "mul_7x6", 1);
    hi_cnt = 0;
    for (int i = 0; i < W; i++) begin
      if (ready_o) hi_cnt++;
      step(1);
    end
    check("ready_low_in_run", W'(hi_cnt), 0);
    drain();

    issue(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min", 1);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max", 1);
    issue(3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "mulhsu_m1x2", 1);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1xmax", 1);
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_m1xm1", 1);
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_m7_2", 1);
    issue(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_m7_2", 1);
    issue(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7", 1);
    issue(3'd7, 32'd100, 32'd7, 32'd2, "remu_100_7", 1);
    issue(3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, "rem_7_m2", 1);
    issue(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, "div_5_0", 1);
    issue(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_5_0", 1);
    issue(3'd7, 32'd5, 32'd0, 32'd5, "remu_5_0", 1);
    issue(3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, "rem_m7_0", 1);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf", 1);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf", 1);
    drain();

    // Hold with ready_i low; valid_i pulses during RUN and DONE must be ignored
    ready_i = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 32'd14, "divu_hold", 1);
    for (int i = 0; i < W + 8; i++) begin
      valid_i = i[0]; op = 3'd0; a = 32'd1; b = 32'd1;
      step(1);
    end
    valid_i = 1'b0;
    check("hold_valid", {{(W-1){1'b0}}, valid_o}, 1);
    check("hold_ready_low", {{(W-1){1'b0}}, ready_o}, 0);
    ready_i = 1'b1;
    step(1);
    check("ready_after_hs", {{(W-1){1'b0}}, ready_o}, 1);
    check("valid_after_hs", {{(W-1){1'b0}}, valid_o}, 0);
    issue(3'd5, 32'd9, 32'd3, 32'd3, "divu_b2b", 1);
    drain();

    // Flush mid-operation
    issue(3'd4, 32'hFFFFFF9C, 32'd7, '0, "div_flushed", 0);
    step(10);
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    check("flush_ready", {{(W-1){1'b0}}, ready_o}, 1);
    check("flush_valid", {{(W-1){1'b0}}, valid_o}, 0);
    step(40);
    issue(3'd0, 32'd3, 32'd4, 32'd12, "mul_after_flush", 1);
    drain();

    // Reset mid-operation
    issue(3'd4, 32'hFFFFFF9C, 32'd7, '0, "div_reset", 0);
    step(10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_ready", {{(W-1){1'b0}}, ready_o}, 1);
    check("rst_valid", {{(W-1){1'b0}}, valid_o}, 0);
    check("rst_result", result, 0);
    step(40);
    issue(3'd0, 32'd3, 32'd4, 32'd12, "mul_after_rst", 1);
    drain();
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
